// File: rtl/inst_fetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue_pkg: shared fetch interface types and constants. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package inst_fetch_queue_pkg;

    localparam int unsigned INST_BYTES = 4;
    localparam int unsigned DISCARD_W  = 16;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ireq_t;

    typedef struct packed {
        logic        valid;
        logic        ready;
        logic [31:0] addr;
        logic [31:0] inst;
        logic [63:0] inst_id;
    } iresp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
        logic [63:0] inst_id;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_fetch_queue_sync_fifo.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue_sync_fifo: power-of-two FIFO with flush and count. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module inst_fetch_queue_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_CNT) || do_pop);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Storage is reset too so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && !do_pop && (count == FULL_CNT)));

endmodule

`default_nettype wire

// File: rtl/inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue: sequential instruction prefetch queue with redirect. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ireq_valid,
    input  logic [31:0] ireq_addr,
    output logic        iresp_valid,
    input  logic        iresp_ready,
    output logic [31:0] iresp_addr,
    output logic [31:0] iresp_inst,
    output logic [63:0] iresp_inst_id,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 2;

    logic [31:0]          pc;
    logic [AW:0]          outstanding;
    logic [DISCARD_W-1:0] discard;
    logic [63:0]          next_id;

    logic [AW:0]          q_count;
    logic [AW:0]          a_count;
    logic                 q_empty;
    logic                 a_empty;
    fetch_entry_t         q_head;
    fetch_entry_t         q_push_entry;
    logic [31:0]          a_head;

    logic                 credit_ok;
    logic                 req_fire;
    logic                 resp_live;
    logic                 q_pop;

    // Queued entries plus live reads may never exceed the queue size, so a
    // returning response always finds room.
    assign credit_ok     = ({1'b0, q_count} + {1'b0, outstanding}) < CW'(QUEUE_DEPTH);
    assign mem_req_valid = rst_n && !ireq_valid && credit_ok;
    assign mem_req_addr  = pc;
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign resp_live     = mem_resp_valid && !ireq_valid && (discard == '0);
    assign q_pop         = iresp_valid && iresp_ready && !ireq_valid;

    assign q_push_entry = '{addr: a_head, inst: mem_resp_data, inst_id: next_id};

    assign iresp_valid   = !q_empty;
    assign iresp_addr    = q_head.addr;
    assign iresp_inst    = q_head.inst;
    assign iresp_inst_id = q_head.inst_id;

    inst_fetch_queue_sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (QUEUE_DEPTH)
    ) u_inst_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (ireq_valid),
        .push      (resp_live),
        .push_data (q_push_entry),
        .pop       (q_pop),
        .head      (q_head),
        .empty     (q_empty),
        .count     (q_count)
    );

    // Holds the PC of every live read; discarded reads are flushed out of it
    // on redirect and consume no entry when they return.
    inst_fetch_queue_sync_fifo #(
        .WIDTH (32),
        .DEPTH (QUEUE_DEPTH)
    ) u_addr_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (ireq_valid),
        .push      (req_fire),
        .push_data (pc),
        .pop       (resp_live),
        .head      (a_head),
        .empty     (a_empty),
        .count     (a_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            next_id     <= '0;
        end else if (ireq_valid) begin
            // Every read still in flight after this cycle belongs to the old stream.
            pc          <= word_align(ireq_addr);
            discard     <= discard + DISCARD_W'(outstanding) - DISCARD_W'(mem_resp_valid);
            outstanding <= '0;
        end else begin
            if (req_fire) begin
                pc <= pc + 32'(INST_BYTES);
            end
            if (mem_resp_valid && (discard != '0)) begin
                discard <= discard - 1'b1;
            end
            unique case ({req_fire, resp_live})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (resp_live) begin
                next_id <= next_id + 64'd1;
            end
        end
    end

    a_addr_tracks_live: assert property (@(posedge clk) disable iff (!rst_n)
        a_count == outstanding);
    a_live_has_addr: assert property (@(posedge clk) disable iff (!rst_n)
        resp_live |-> !a_empty);

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_queue: scoreboard bench with in-order memory model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        iresp_valid;
    logic        iresp_ready;
    logic [31:0] iresp_addr;
    logic [31:0] iresp_inst;
    logic [63:0] iresp_inst_id;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    always #5 clk = ~clk;

    inst_fetch_queue #(
        .QUEUE_DEPTH (4),
        .RESET_PC    (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_valid    (iresp_valid),
        .iresp_ready    (iresp_ready),
        .iresp_addr     (iresp_addr),
        .iresp_inst     (iresp_inst),
        .iresp_inst_id  (iresp_inst_id),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
        int          epoch;
    } mreq_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic [63:0] id;
    } exp_t;

    typedef struct {
        logic        irq;
        logic [31:0] iaddr;
        logic        rdy;
        logic        mrdy;
        int          lat;
        int          cycles;
        int          exp_reqs;
    } phase_t;

    mreq_t       pend[$];
    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cycle    = 0;
    int          epoch    = 0;
    int          lat      = 1;
    int          phase_reqs;
    logic [31:0] exp_pc   = 32'h0;
    logic [63:0] exp_id   = 64'd0;
    logic        seen_200 = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cycle, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string nm);
        check({nm, "_iresp_valid"}, 64'(iresp_valid), 64'd0);
        check({nm, "_mem_req_valid"}, 64'(mem_req_valid), 64'd0);
        check({nm, "_iresp_addr"}, 64'(iresp_addr), 64'd0);
        check({nm, "_iresp_inst"}, 64'(iresp_inst), 64'd0);
        check({nm, "_iresp_inst_id"}, iresp_inst_id, 64'd0);
    endtask

    // One clock: check outputs against the model, advance the edge, update model.
    task automatic tick();
        logic fire, resp, pop, exp_rv;
        int   live;
        mreq_t r;
        #1;
        live = 0;
        foreach (pend[i]) if (pend[i].epoch == epoch) live++;
        exp_rv = !ireq_valid && ((sb.size() + live) < 4);
        check("mem_req_valid", 64'(mem_req_valid), 64'(exp_rv));
        check("iresp_valid", 64'(iresp_valid), 64'(sb.size() != 0));
        if (iresp_valid && sb.size() != 0) begin
            check("iresp_addr", 64'(iresp_addr), 64'(sb[0].addr));
            check("iresp_inst", 64'(iresp_inst), 64'(sb[0].inst));
            check("iresp_inst_id", iresp_inst_id, sb[0].id);
        end
        fire = mem_req_valid && mem_req_ready;
        resp = mem_resp_valid;
        pop  = iresp_valid && iresp_ready && !ireq_valid;
        if (fire) begin
            check("mem_req_addr", 64'(mem_req_addr), 64'(exp_pc));
            if (mem_req_addr == 32'h200) seen_200 = 1'b1;
            phase_reqs++;
        end
        @(posedge clk);
        #1;
        cycle++;
        if (ireq_valid) begin
            sb.delete();
            epoch++;
            exp_pc = {ireq_addr[31:2], 2'b00};
            if (resp) void'(pend.pop_front());
        end else begin
            if (pop) void'(sb.pop_front());
            if (resp) begin
                r = pend.pop_front();
                if (r.epoch == epoch) begin
                    sb.push_back('{r.addr, r.data, exp_id});
                    exp_id++;
                end
            end
            if (fire) begin
                pend.push_back('{exp_pc, mem_word(exp_pc), cycle + lat - 1, epoch});
                exp_pc += 32'd4;
            end
        end
        if (pend.size() != 0 && pend[0].due <= cycle) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = pend[0].data;
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = 32'h0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        phase_t tbl[11];
        int     k;
        tbl[0]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1, 10, -1};
        tbl[1]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1, 16, 16};
        tbl[2]  = '{1'b1, 32'h40,  1'b0, 1'b1, 1,  1,  0};
        tbl[3]  = '{1'b0, 32'h0,   1'b0, 1'b1, 1, 12,  4};
        tbl[4]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1,  1,  0};
        tbl[5]  = '{1'b0, 32'h0,   1'b0, 1'b1, 1,  5,  1};
        tbl[6]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1,  8, -1};
        tbl[7]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1,  6,  0};
        tbl[8]  = '{1'b0, 32'h0,   1'b1, 1'b1, 3, 12, -1};
        tbl[9]  = '{1'b1, 32'h103, 1'b1, 1'b1, 3,  1,  0};
        tbl[10] = '{1'b0, 32'h0,   1'b1, 1'b1, 3, 12, -1};

        rst_n          = 1'b0;
        ireq_valid     = 1'b0;
        ireq_addr      = 32'h0;
        iresp_ready    = 1'b1;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        for (int p = 0; p < 11; p++) begin
            ireq_valid    = tbl[p].irq;
            ireq_addr     = tbl[p].iaddr;
            iresp_ready   = tbl[p].rdy;
            mem_req_ready = tbl[p].mrdy;
            lat           = tbl[p].lat;
            phase_reqs    = 0;
            run(tbl[p].cycles);
            if (tbl[p].exp_reqs >= 0)
                check($sformatf("phase%0d_reqs", p), 64'(phase_reqs), 64'(tbl[p].exp_reqs));
        end
        ireq_valid = 1'b0;

        // Redirect landing on a cycle with both a response and a pop.
        lat = 3; iresp_ready = 1'b0; mem_req_ready = 1'b1;
        ireq_valid = 1'b1; ireq_addr = 32'h80; tick();
        ireq_valid = 1'b0;
        k = 0;
        while (!(mem_resp_valid && iresp_valid) && k < 30) begin tick(); k++; end
        check("coincide_found", 64'(k < 30), 64'd1);
        iresp_ready = 1'b1; ireq_valid = 1'b1; ireq_addr = 32'h180; tick();
        ireq_valid = 1'b0;
        run(12);

        // Back-to-back redirects: only the second stream may appear.
        lat = 1; seen_200 = 1'b0;
        ireq_valid = 1'b1; ireq_addr = 32'h200; tick();
        ireq_addr = 32'h300; tick();
        ireq_valid = 1'b0;
        k = 0;
        while (!iresp_valid && k < 20) begin tick(); k++; end
        check("b2b_first_addr", 64'(iresp_addr), 64'h300);
        run(8);
        check("b2b_no_200", 64'(seen_200), 64'd0);

        // Asynchronous reset with entries queued and reads in flight.
        lat = 3; iresp_ready = 1'b0;
        ireq_valid = 1'b1; ireq_addr = 32'h400; tick();
        ireq_valid = 1'b0;
        run(5);
        check("pre_reset_valid", 64'(iresp_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        sb.delete(); pend.delete(); epoch++;
        exp_pc = 32'h0; exp_id = 64'd0;
        mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; iresp_ready = 1'b1; lat = 1;
        run(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
